// File: rtl/fractal_sync_mc_fifo.sv
// Multi-channel FIFO: one circular buffer per input channel, merged onto a single
// round-robin output with optional fall-through and a grant lock while stalled.
module fractal_sync_mc_fifo #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned N_CHANNELS   = 2,
  parameter type         fifo_t       = logic,
  parameter bit          COMB_OUT     = 1'b1,
  parameter int unsigned AFULL_THRESH = FIFO_DEPTH - 1,
  localparam int unsigned CH_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CHANNELS-1:0] flush_i,
  input  logic [N_CHANNELS-1:0] push_valid_i,
  input  fifo_t                 push_data_i [N_CHANNELS],
  output logic [N_CHANNELS-1:0] push_ready_o,
  output logic                  pop_valid_o,
  output fifo_t                 pop_data_o,
  output logic [CH_W-1:0]       pop_ch_o,
  input  logic                  pop_ready_i,
  output logic [CNT_W-1:0]      count_o [N_CHANNELS],
  output logic [N_CHANNELS-1:0] afull_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  fifo_t                 mem    [N_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr [N_CHANNELS];
  logic [PTR_W-1:0]      wr_ptr [N_CHANNELS];
  logic [CH_W-1:0]       prio;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       lock_ch;
  logic                  lock_vld;
  logic                  grant_vld;
  logic                  pop_done;
  logic [N_CHANNELS-1:0] push_acc;
  logic [N_CHANNELS-1:0] eligible;
  logic [N_CHANNELS-1:0] pop_sel;
  logic [N_CHANNELS-1:0] mem_wr;
  logic [N_CHANNELS-1:0] mem_rd;
  logic [CH_W:0]         idx_sum;
  logic [CH_W-1:0]       cand;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < int'(N_CHANNELS); c++) begin
      push_ready_o[c] = (count_o[c] != CNT_W'(FIFO_DEPTH));
      push_acc[c]     = push_valid_i[c] & push_ready_o[c];
      eligible[c]     = (count_o[c] != '0) | (COMB_OUT & push_acc[c]);
      afull_o[c]      = (count_o[c] >= CNT_W'(AFULL_THRESH));
    end
  end

  // A locked grant wins outright; otherwise scan from prio with wrap-around.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx_sum   = '0;
    cand      = '0;
    if (lock_vld) begin
      grant_vld = 1'b1;
      grant     = lock_ch;
    end else begin
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        idx_sum = {1'b0, prio} + (CH_W+1)'(i);
        if (idx_sum >= (CH_W+1)'(N_CHANNELS)) idx_sum = idx_sum - (CH_W+1)'(N_CHANNELS);
        cand = idx_sum[CH_W-1:0];
        if (!grant_vld && eligible[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  always_comb begin
    pop_valid_o = grant_vld;
    pop_data_o  = '0;
    pop_ch_o    = '0;
    if (grant_vld) begin
      pop_ch_o   = grant;
      pop_data_o = (count_o[grant] == '0) ? push_data_i[grant] : mem[grant][rd_ptr[grant]];
    end
  end

  assign pop_done = grant_vld & pop_ready_i;

  // A fall-through element consumed in its arrival cycle never touches memory.
  always_comb begin
    for (int c = 0; c < int'(N_CHANNELS); c++) begin
      pop_sel[c] = pop_done && (grant == CH_W'(c));
      mem_wr[c]  = push_acc[c] && !flush_i[c] && !(pop_sel[c] && (count_o[c] == '0));
      mem_rd[c]  = pop_sel[c] && (count_o[c] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < int'(N_CHANNELS); c++) begin
      if (mem_wr[c]) mem[c][wr_ptr[c]] <= push_data_i[c];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < int'(N_CHANNELS); c++) begin
      if (rst_i || flush_i[c]) begin
        count_o[c] <= '0;
        rd_ptr[c]  <= '0;
        wr_ptr[c]  <= '0;
      end else begin
        if (mem_wr[c]) wr_ptr[c] <= next_ptr(wr_ptr[c]);
        if (mem_rd[c]) rd_ptr[c] <= next_ptr(rd_ptr[c]);
        case ({mem_wr[c], mem_rd[c]})
          2'b10:   count_o[c] <= count_o[c] + CNT_W'(1);
          2'b01:   count_o[c] <= count_o[c] - CNT_W'(1);
          default: count_o[c] <= count_o[c];
        endcase
      end
    end
  end

  // Flushing the granted channel drops the lock so arbitration restarts cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio     <= '0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else begin
      lock_vld <= grant_vld && !pop_ready_i && !flush_i[grant];
      lock_ch  <= grant;
      if (pop_done) prio <= (grant == CH_W'(N_CHANNELS - 1)) ? '0 : grant + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_fractal_sync_mc_fifo.sv
// Scoreboard bench: a queue-based model predicts each cycle's outputs for a
// fall-through DUT and a registered-output DUT driven by identical stimulus.
module tb_fractal_sync_mc_fifo;

  localparam int D = 3;

  typedef struct packed {
    logic       vld;
    logic       ch;
    logic [7:0] dat;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] rdy;
    logic [1:0] af;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] flush_i = '0;
  logic [1:0] push_valid_i = '0;
  logic [7:0] push_data_i [2];
  logic       pop_ready_i = 1'b0;

  logic [1:0] ft_push_ready, rg_push_ready;
  logic       ft_pop_valid, rg_pop_valid;
  logic [7:0] ft_pop_data, rg_pop_data;
  logic [0:0] ft_pop_ch, rg_pop_ch;
  logic [1:0] ft_count [2];
  logic [1:0] rg_count [2];
  logic [1:0] ft_afull, rg_afull;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq [2][2][$];
  int         mp [2];
  bit         mlk [2];
  logic       mlch [2];
  exp_t       exp_q [2][$];

  always #5 clk = ~clk;

  fractal_sync_mc_fifo #(.FIFO_DEPTH(D), .N_CHANNELS(2), .fifo_t(logic [7:0]), .COMB_OUT(1'b1)) u_ft (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .push_valid_i(push_valid_i),
    .push_data_i(push_data_i), .push_ready_o(ft_push_ready), .pop_valid_o(ft_pop_valid),
    .pop_data_o(ft_pop_data), .pop_ch_o(ft_pop_ch), .pop_ready_i(pop_ready_i),
    .count_o(ft_count), .afull_o(ft_afull));

  fractal_sync_mc_fifo #(.FIFO_DEPTH(D), .N_CHANNELS(2), .fifo_t(logic [7:0]), .COMB_OUT(1'b0)) u_rg (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .push_valid_i(push_valid_i),
    .push_data_i(push_data_i), .push_ready_o(rg_push_ready), .pop_valid_o(rg_pop_valid),
    .pop_data_o(rg_pop_data), .pop_ch_o(rg_pop_ch), .pop_ready_i(pop_ready_i),
    .count_o(rg_count), .afull_o(rg_afull));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model k=0 has fall-through, k=1 does not. Computes this cycle's outputs, then advances.
  task automatic model_step(input int k);
    exp_t e;
    int   g;
    logic gc;
    bit   comb;
    bit   acc [2];
    bit   elig [2];
    bit   done;
    comb = (k == 0);
    g    = -1;
    for (int c = 0; c < 2; c++) begin
      acc[c]  = push_valid_i[c] && (mq[k][c].size() != D);
      elig[c] = (mq[k][c].size() != 0) || (comb && acc[c]);
    end
    if (mlk[k]) g = int'(mlch[k]);
    else begin
      for (int i = 0; i < 2; i++) begin
        int c;
        c = (mp[k] + i) % 2;
        if (g < 0 && elig[c]) g = c;
      end
    end
    e  = '0;
    gc = (g == 1);
    if (g >= 0) begin
      e.vld = 1'b1;
      e.ch  = gc;
      e.dat = (mq[k][gc].size() != 0) ? mq[k][gc][0] : push_data_i[gc];
    end
    e.c0  = 2'(mq[k][0].size());
    e.c1  = 2'(mq[k][1].size());
    e.rdy = {mq[k][1].size() != D, mq[k][0].size() != D};
    e.af  = {mq[k][1].size() >= D - 1, mq[k][0].size() >= D - 1};
    exp_q[k].push_back(e);
    done = e.vld && pop_ready_i;
    if (rst_i) begin
      mq[k][0].delete();
      mq[k][1].delete();
      mp[k]  = 0;
      mlk[k] = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (flush_i[c]) mq[k][c].delete();
        else begin
          bit was_empty;
          bit popc;
          was_empty = (mq[k][c].size() == 0);
          popc      = done && (g == c);
          if (popc && !was_empty) void'(mq[k][c].pop_front());
          if (acc[c] && !(popc && was_empty)) mq[k][c].push_back(push_data_i[c]);
        end
      end
      mlk[k]  = e.vld && !pop_ready_i && !flush_i[gc];
      mlch[k] = gc;
      if (done) mp[k] = (g + 1) % 2;
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] fl, input logic [1:0] pv,
                     input logic [7:0] d0, input logic [7:0] d1, input logic pr);
    rst_i          = r;
    flush_i        = fl;
    push_valid_i   = pv;
    push_data_i[0] = d0;
    push_data_i[1] = d1;
    pop_ready_i    = pr;
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (exp_q[k].size() > 0) begin
          logic       a_vld;
          logic [7:0] a_dat;
          logic       a_ch;
          logic [1:0] a_c0, a_c1, a_rdy, a_af;
          e = exp_q[k].pop_front();
          if (k == 0) begin
            a_vld = ft_pop_valid; a_dat = ft_pop_data; a_ch = ft_pop_ch[0];
            a_c0 = ft_count[0]; a_c1 = ft_count[1]; a_rdy = ft_push_ready; a_af = ft_afull;
          end else begin
            a_vld = rg_pop_valid; a_dat = rg_pop_data; a_ch = rg_pop_ch[0];
            a_c0 = rg_count[0]; a_c1 = rg_count[1]; a_rdy = rg_push_ready; a_af = rg_afull;
          end
          chk("pop_valid", k, 32'(a_vld), 32'(e.vld));
          chk("pop_ch",    k, 32'(a_ch),  32'(e.ch));
          chk("pop_data",  k, 32'(a_dat), 32'(e.dat));
          chk("count0",    k, 32'(a_c0),  32'(e.c0));
          chk("count1",    k, 32'(a_c1),  32'(e.c1));
          chk("push_ready",k, 32'(a_rdy), 32'(e.rdy));
          chk("afull",     k, 32'(a_af),  32'(e.af));
        end
      end
    end
  end

  initial begin
    push_data_i[0] = '0;
    push_data_i[1] = '0;
    for (int k = 0; k < 2; k++) begin
      mp[k] = 0; mlk[k] = 1'b0; mlch[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // fill/drain on channel 0
    cyc(0, 2'b00, 2'b01, 8'hA1, 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'hB2, 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'hC3, 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'hDD, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // round-robin with both channels holding two elements
    cyc(0, 2'b00, 2'b11, 8'h10, 8'h20, 0);
    cyc(0, 2'b00, 2'b11, 8'h11, 8'h21, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // stall lock on channel 1 while channel 0 fills
    cyc(0, 2'b00, 2'b10, 8'h00, 8'h5A, 0);
    cyc(0, 2'b00, 2'b01, 8'h31, 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'h32, 8'h00, 0);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // fall-through into an empty channel
    cyc(0, 2'b00, 2'b01, 8'h77, 8'h00, 1);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // full boundary: push while full and popping is ignored
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 2'b01, 8'(8'h40 + i), 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'h4F, 8'h00, 1);
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // wrap-around over ten elements on channel 0
    for (int i = 0; i < 10; i++) cyc(0, 2'b00, 2'b01, 8'(8'h60 + i), 8'h00, logic'(i % 3 == 2));
    for (int i = 0; i < 8; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // flush with a concurrent push
    cyc(0, 2'b00, 2'b01, 8'h81, 8'h00, 0);
    cyc(0, 2'b00, 2'b01, 8'h82, 8'h00, 0);
    cyc(0, 2'b01, 2'b01, 8'h83, 8'h00, 0);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // reset in the middle of traffic
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b11, 8'(8'h90 + i), 8'(8'hA0 + i), 0);
    cyc(1, 2'b00, 2'b11, 8'h9F, 8'hAF, 1);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 63) == 0),
          {logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 15) == 0)},
          2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          logic'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 8; i++) cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("drain", k, 32'(exp_q[k].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
